// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants: FSM states, reset PC, exception vector.
package fetch_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ     = 3'd1,
    WAIT    = 3'd2,
    HOLD    = 3'd3,
    DISCARD = 3'd4
  } fetch_state_t;

  localparam logic [31:0] RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] EXC_VECTOR = 32'h0000_4180;

  // Memory is word addressed; misaligned PCs are flagged downstream, not here.
  function automatic logic [31:0] word_addr(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/npc_sel.sv
// Redirect priority select: exc_req > eret > br_taken > jmp; stall masks branch/jump.
// Purely combinational, no backpressure.
module npc_sel
  import fetch_pkg::*;
(
  input  logic        stall,
  input  logic        exc_req,
  input  logic        eret,
  input  logic [31:0] epc,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        jmp,
  input  logic [31:0] jmp_target,
  output logic        redirect,
  output logic [31:0] target
);

  always_comb begin
    redirect = 1'b0;
    target   = 32'h0;
    if (exc_req) begin
      redirect = 1'b1;
      target   = EXC_VECTOR;
    end else if (eret) begin
      redirect = 1'b1;
      target   = epc;
    end else if (!stall && br_taken) begin
      redirect = 1'b1;
      target   = br_target;
    end else if (!stall && jmp) begin
      redirect = 1'b1;
      target   = jmp_target;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: one outstanding imem request, redirect handling, stall hold.
// Instruction appears one cycle after imem_rvalid; stall holds it, exc/eret kill it.
module fetch_ctrl
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        exc_req,
  input  logic        eret,
  input  logic [31:0] epc,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        jmp,
  input  logic [31:0] jmp_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] pc_out
);

  fetch_state_t state, state_nxt;
  logic         redirect;
  logic [31:0]  target;
  logic         take;
  logic         deliver;

  npc_sel u_npc_sel (
    .stall      (stall),
    .exc_req    (exc_req),
    .eret       (eret),
    .epc        (epc),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .jmp        (jmp),
    .jmp_target (jmp_target),
    .redirect   (redirect),
    .target     (target)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = REQ;
      REQ: begin
        if (imem_gnt) state_nxt = redirect ? DISCARD : WAIT;
      end
      WAIT: begin
        if (redirect)         state_nxt = imem_rvalid ? REQ : DISCARD;
        else if (imem_rvalid) state_nxt = stall ? HOLD : REQ;
      end
      HOLD: begin
        if (redirect || !stall) state_nxt = REQ;
      end
      DISCARD: begin
        if (imem_rvalid) state_nxt = REQ;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    imem_req = 1'b0;
    deliver  = 1'b0;
    take     = 1'b0;
    case (state)
      REQ: begin
        imem_req = 1'b1;
        take     = redirect;
      end
      WAIT: begin
        deliver = imem_rvalid && !redirect;
        take    = redirect;
      end
      HOLD, DISCARD: take = redirect;
      default: ;
    endcase
  end

  assign imem_addr = word_addr(pc);

  // A stalled consumer keeps the instruction unless exc/eret kills it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc          <= RESET_PC;
      pc_out      <= RESET_PC;
      instr       <= 32'h0;
      instr_valid <= 1'b0;
    end else begin
      if (take) begin
        pc <= target;
      end else if (deliver) begin
        pc <= pc + 32'd4;
      end
      if (deliver) begin
        instr  <= imem_rdata;
        pc_out <= pc;
      end
      instr_valid <= deliver || (instr_valid && stall && !take);
    end
  end

  a_rvalid_outstanding: assert property (
    @(posedge clk) disable iff (reset)
    imem_rvalid |-> (state == WAIT || state == DISCARD)
  );

endmodule
